// File: rtl/xmpl_stone_pkg.sv
// Shared types and status-word layout for the xmpl_stone_bank accumulator block.
package xmpl_stone_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  localparam int ST_SAT_LSB   = 0;
  localparam int ST_CNT_LSB   = 8;
  localparam int ST_CNT_W     = 8;
  localparam int ST_STATE_LSB = 16;
  localparam int ST_FULL_BIT  = 24;
  localparam int ST_EMPTY_BIT = 25;

endpackage

// File: rtl/xmpl_stone_fifo.sv
// Synchronous power-of-two FIFO with registered occupancy count and a
// combinational head word.
module xmpl_stone_fifo #(
  parameter  int WIDTH = 44,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/xmpl_stone_bank.sv
// Multi-channel saturating accumulator bank: queued commands are executed by
// an IDLE/EXEC/WB sequencer, one retirement every three cycles.
module xmpl_stone_bank
  import xmpl_stone_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_W     = 32,
  parameter  int CMD_W      = 12,
  parameter  int FIFO_DEPTH = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              xmpl_stone_a_i,
  output logic              xmpl_stone_ready_o,
  input  logic [CMD_W-1:0]  xmpl_stone_b_i,
  input  logic [DATA_W-1:0] xmpl_stone_c_i,
  input  logic [CH_W-1:0]   xmpl_stone_rd_sel_i,
  output logic [DATA_W-1:0] xmpl_stone_rd_data_o,
  output logic              xmpl_stone_done_o,
  output logic              xmpl_stone_busy_o,
  output logic [DATA_W-1:0] xmpl_stone_status_o
);

  localparam int ENT_W = CMD_W + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ENT_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_push;
  logic             fifo_pop;
  logic             unused_head;

  state_e            state_q;
  op_e               op_q;
  logic [CH_W-1:0]   ch_q;
  logic [DATA_W-1:0] opnd_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] res_d;
  logic              sat_q;
  logic              sat_d;
  logic              done_q;
  logic [DATA_W-1:0] acc_q [NUM_CH];
  logic [NUM_CH-1:0] flag_q;
  logic [DATA_W-1:0] acc_cur;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;

  // Valid/ready: a command transfers on a rising edge where a_i && ready_o;
  // b_i/c_i are sampled on that edge, and a source seeing ready_o low must hold.
  assign xmpl_stone_ready_o = !fifo_full;
  assign fifo_push          = xmpl_stone_a_i && xmpl_stone_ready_o;
  assign fifo_pop           = (state_q == ST_IDLE) && !fifo_empty;
  assign unused_head        = ^fifo_head;

  xmpl_stone_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (fifo_push),
    .data_i    ({xmpl_stone_b_i, xmpl_stone_c_i}),
    .pop_i     (fifo_pop),
    .data_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Arithmetic is one bit wider than the accumulator; the top bit flags the clamp.
  always_comb begin
    acc_cur = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) acc_cur = acc_q[i];
    end
    sum   = {1'b0, acc_cur} + {1'b0, opnd_q};
    diff  = {1'b0, acc_cur} - {1'b0, opnd_q};
    res_d = opnd_q;
    sat_d = 1'b0;
    case (op_q)
      OP_LOAD:  res_d = opnd_q;
      OP_ADD: begin
        res_d = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
        sat_d = sum[DATA_W];
      end
      OP_SUB: begin
        res_d = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
        sat_d = diff[DATA_W];
      end
      OP_CLEAR: res_d = '0;
      default:  res_d = opnd_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      ch_q    <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
      flag_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            op_q    <= op_e'(fifo_head[ENT_W-1 -: 2]);
            ch_q    <= fifo_head[DATA_W +: CH_W];
            opnd_q  <= fifo_head[DATA_W-1:0];
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q   <= res_d;
          sat_q   <= sat_d;
          state_q <= ST_WB;
        end
        ST_WB: begin
          // A channel index with no matching register retires without effect.
          for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
              acc_q[i] <= res_q;
              if (op_q == OP_CLEAR) flag_q[i] <= 1'b0;
              else if (sat_q)       flag_q[i] <= 1'b1;
            end
          end
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    xmpl_stone_rd_data_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (xmpl_stone_rd_sel_i == CH_W'(i)) xmpl_stone_rd_data_o = acc_q[i];
    end
  end

  always_comb begin
    xmpl_stone_status_o = '0;
    xmpl_stone_status_o[ST_SAT_LSB +: NUM_CH]     = flag_q;
    xmpl_stone_status_o[ST_CNT_LSB +: ST_CNT_W]   = ST_CNT_W'(fifo_count);
    xmpl_stone_status_o[ST_STATE_LSB +: 2]        = state_q;
    xmpl_stone_status_o[ST_FULL_BIT]              = fifo_full;
    xmpl_stone_status_o[ST_EMPTY_BIT]             = fifo_empty;
  end

  assign xmpl_stone_done_o = done_q;
  assign xmpl_stone_busy_o = (state_q != ST_IDLE) || !fifo_empty;

endmodule
